// File: rtl/instr_loader_pkg.sv
// Shared CPU package: loader FSM encoding, stream byte layout and instruction word sizing.
package instr_loader_pkg;

    localparam int unsigned InstrW = 10;              // instruction word width
    localparam int unsigned AddrW  = 10;              // instruction-memory address width
    localparam int unsigned ByteW  = 8;               // stream byte width
    localparam int unsigned HiBits = InstrW - ByteW;  // payload bits carried by a HI byte

    localparam logic [ByteW-1:0] ChkInit = 8'h00;     // XOR checksum seed

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StCntHi = 3'd1,
        StCntLo = 3'd2,
        StWHi   = 3'd3,
        StWLo   = 3'd4,
        StChk   = 3'd5,
        StFin   = 3'd6
    } load_state_e;

    // A load fits when its last word lands at or below the top of memory.
    function automatic logic load_fits(input logic [AddrW-1:0] base,
                                       input logic [AddrW-1:0] count,
                                       input int unsigned      max_words);
        return (32'(base) + 32'(count)) <= max_words;
    endfunction

endpackage

// File: rtl/instr_loader.sv
// Byte-stream instruction loader: parses count, words and an XOR checksum,
// writes words into instruction memory and holds the CPU while loading.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter logic [AddrW-1:0] BASE_ADDR = 10'd0,
    parameter int unsigned      MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [ByteW-1:0]  in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [AddrW-1:0]  mem_addr,
    output logic [InstrW-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    load_state_e       state_q;
    logic [AddrW-1:0]  count_q;
    logic [AddrW-1:0]  index_q;
    logic [ByteW-1:0]  chk_q;
    logic [HiBits-1:0] hi_q;
    logic              mem_we_q;
    logic [AddrW-1:0]  mem_addr_q;
    logic [InstrW-1:0] mem_wdata_q;
    logic              cpu_hold_q;
    logic              done_q;
    logic              err_q;

    logic              xfer;
    logic [AddrW-1:0]  count_full;
    logic [AddrW-1:0]  index_inc;

    // Byte acceptance is a pure decode of the current state.
    always_comb begin
        in_ready = 1'b0;
        unique case (state_q)
            StCntHi, StCntLo, StWHi, StWLo, StChk: in_ready = 1'b1;
            default:                               in_ready = 1'b0;
        endcase
    end

    assign xfer       = in_valid & in_ready;
    assign count_full = {count_q[AddrW-1:ByteW], in_data};
    assign index_inc  = index_q + 10'd1;

    // Loader FSM with all outputs registered; reset wins over any pending transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            count_q     <= '0;
            index_q     <= '0;
            chk_q       <= ChkInit;
            hi_q        <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_hold_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            done_q   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q    <= StCntHi;
                        err_q      <= 1'b0;
                        cpu_hold_q <= 1'b1;
                        chk_q      <= ChkInit;
                        index_q    <= '0;
                    end
                end
                StCntHi: begin
                    if (xfer) begin
                        count_q[AddrW-1:ByteW] <= in_data[HiBits-1:0];
                        chk_q                  <= chk_q ^ in_data;
                        state_q                <= StCntLo;
                    end
                end
                StCntLo: begin
                    if (xfer) begin
                        count_q <= count_full;
                        chk_q   <= chk_q ^ in_data;
                        index_q <= '0;
                        if (!load_fits(BASE_ADDR, count_full, MAX_WORDS)) begin
                            // Oversized load: abort before any write, stop consuming bytes.
                            err_q      <= 1'b1;
                            done_q     <= 1'b1;
                            cpu_hold_q <= 1'b0;
                            state_q    <= StFin;
                        end else if (count_full == '0) begin
                            state_q <= StChk;
                        end else begin
                            state_q <= StWHi;
                        end
                    end
                end
                StWHi: begin
                    if (xfer) begin
                        hi_q    <= in_data[HiBits-1:0];
                        chk_q   <= chk_q ^ in_data;
                        state_q <= StWLo;
                    end
                end
                StWLo: begin
                    if (xfer) begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= BASE_ADDR + index_q;
                        mem_wdata_q <= {hi_q, in_data};
                        chk_q       <= chk_q ^ in_data;
                        index_q     <= index_inc;
                        state_q     <= (index_inc == count_q) ? StChk : StWHi;
                    end
                end
                StChk: begin
                    if (xfer) begin
                        err_q      <= err_q | (in_data != chk_q);
                        done_q     <= 1'b1;
                        cpu_hold_q <= 1'b0;
                        state_q    <= StFin;
                    end
                end
                StFin: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: two instances (base 0 and base 2) share clock and reset.
module tb_instr_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start_a, valid_a, ready_a, we_a, hold_a, done_a, err_a;
    logic [7:0] data_a;
    logic [9:0] addr_a, wdata_a;
    logic       start_b, valid_b, ready_b, we_b, hold_b, done_b, err_b;
    logic [7:0] data_b;
    logic [9:0] addr_b, wdata_b;

    instr_loader u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .in_valid(valid_a), .in_data(data_a),
        .in_ready(ready_a), .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wdata_a),
        .cpu_hold(hold_a), .done(done_a), .err(err_a)
    );

    instr_loader #(.BASE_ADDR(10'd2), .MAX_WORDS(1024)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .in_valid(valid_b), .in_data(data_b),
        .in_ready(ready_b), .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wdata_b),
        .cpu_hold(hold_b), .done(done_b), .err(err_b)
    );

    int checks = 0;
    int errors = 0;

    // Write/done logs and the in_ready == cpu_hold invariant (in_ready only in byte states).
    int         wr_a_n = 0, wr_b_n = 0, done_a_n = 0, done_b_n = 0, inv_bad = 0;
    logic [9:0] wr_a_addr [64];
    logic [9:0] wr_a_data [64];
    logic [9:0] wr_b_addr [64];
    logic [9:0] wr_b_data [64];

    always @(negedge clk) begin
        if (we_a === 1'b1) begin
            if (wr_a_n < 64) begin
                wr_a_addr[wr_a_n] <= addr_a;
                wr_a_data[wr_a_n] <= wdata_a;
            end
            wr_a_n <= wr_a_n + 1;
        end
        if (we_b === 1'b1) begin
            if (wr_b_n < 64) begin
                wr_b_addr[wr_b_n] <= addr_b;
                wr_b_data[wr_b_n] <= wdata_b;
            end
            wr_b_n <= wr_b_n + 1;
        end
        if (done_a === 1'b1) done_a_n <= done_a_n + 1;
        if (done_b === 1'b1) done_b_n <= done_b_n + 1;
        if ((ready_a !== hold_a) || (ready_b !== hold_b)) inv_bad <= inv_bad + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input bit sel_b);
        @(negedge clk);
        if (sel_b) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // One byte: optional idle gap, then hold valid until the loader takes it.
    task automatic send(input bit sel_b, input logic [7:0] b, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        if (sel_b) begin valid_b = 1'b1; data_b = b; end
        else       begin valid_a = 1'b1; data_a = b; end
        n = 0;
        while (!(sel_b ? ready_b : ready_a) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("ready_wait", {31'd0, sel_b ? ready_b : ready_a}, 32'd1);
        @(posedge clk);
        #1;
        valid_a = 1'b0;
        valid_b = 1'b0;
    endtask

    // Bytes are listed left to right in stream order.
    task automatic send_stream(input bit sel_b, input logic [127:0] bytes, input int n,
                               input int maxgap);
        int gap;
        for (int i = 0; i < n; i++) begin
            gap = (maxgap == 0) ? 0 : int'($urandom_range(maxgap, 0));
            send(sel_b, bytes[8*(n-1-i) +: 8], gap);
        end
    endtask

    task automatic check_three_words(input string tag, input int base);
        check({tag, "_nwr"}, wr_a_n - base, 3);
        check({tag, "_a0"}, {22'd0, wr_a_addr[base]},     32'h000);
        check({tag, "_d0"}, {22'd0, wr_a_data[base]},     32'h2FD);
        check({tag, "_a1"}, {22'd0, wr_a_addr[base + 1]}, 32'h001);
        check({tag, "_d1"}, {22'd0, wr_a_data[base + 1]}, 32'h105);
        check({tag, "_a2"}, {22'd0, wr_a_addr[base + 2]}, 32'h002);
        check({tag, "_d2"}, {22'd0, wr_a_data[base + 2]}, 32'h3C0);
    endtask

    int wb, db;

    initial begin
        rst_n   = 1'b0;
        start_a = 1'b0; valid_a = 1'b0; data_a = 8'h00;
        start_b = 1'b0; valid_b = 1'b0; data_b = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, ready_a}, 0);
        check("rst_we",    {31'd0, we_a},    0);
        check("rst_addr",  {22'd0, addr_a},  0);
        check("rst_wdata", {22'd0, wdata_a}, 0);
        check("rst_hold",  {31'd0, hold_a},  0);
        check("rst_done",  {31'd0, done_a},  0);
        check("rst_err",   {31'd0, err_a},   0);
        check("rst_err_b", {31'd0, err_b},   0);
        @(negedge clk);
        rst_n = 1'b1;

        // Three-word load with a correct checksum.
        wb = wr_a_n; db = done_a_n;
        pulse_start(0);
        check("t1_hold_on", {31'd0, hold_a},  1);
        check("t1_ready",   {31'd0, ready_a}, 1);
        send_stream(0, 72'h00_03_02_FD_01_05_03_C0_3B, 9, 0);
        check("t1_done",    {31'd0, done_a}, 1);
        check("t1_hold_off",{31'd0, hold_a}, 0);
        @(posedge clk); #1;
        check("t1_done_1cy",{31'd0, done_a}, 0);
        repeat (2) @(posedge clk); #1;
        check_three_words("t1", wb);
        check("t1_err",     {31'd0, err_a}, 0);
        check("t1_ndone",   done_a_n - db,  1);
        check("t1_addr_hold",  {22'd0, addr_a},  32'h002);
        check("t1_wdata_hold", {22'd0, wdata_a}, 32'h3C0);

        // Bad checksum: writes still happen, err sticks until the next start.
        wb = wr_a_n; db = done_a_n;
        pulse_start(0);
        send_stream(0, 72'h00_03_02_FD_01_05_03_C0_3A, 9, 0);
        repeat (5) @(posedge clk); #1;
        check_three_words("t2", wb);
        check("t2_err",   {31'd0, err_a}, 1);
        check("t2_ndone", done_a_n - db,  1);

        // Count 0, with start and a stray valid byte together in IDLE.
        wb = wr_a_n; db = done_a_n;
        @(negedge clk);
        start_a = 1'b1; valid_a = 1'b1; data_a = 8'h55;
        @(posedge clk); #1;
        start_a = 1'b0; valid_a = 1'b0;
        check("t3_err_clr", {31'd0, err_a},  0);
        check("t3_hold",    {31'd0, hold_a}, 1);
        send_stream(0, 24'h00_00_00, 3, 0);
        check("t3_done", {31'd0, done_a}, 1);
        repeat (2) @(posedge clk); #1;
        check("t3_nwr",  wr_a_n - wb,    0);
        check("t3_err",  {31'd0, err_a}, 0);

        // Random valid gaps.
        wb = wr_a_n; db = done_a_n;
        pulse_start(0);
        send_stream(0, 72'h00_03_02_FD_01_05_03_C0_3B, 9, 5);
        repeat (3) @(posedge clk); #1;
        check_three_words("t4", wb);
        check("t4_err",   {31'd0, err_a}, 0);
        check("t4_ndone", done_a_n - db,  1);

        // start pulsed mid-load is ignored.
        wb = wr_a_n; db = done_a_n;
        pulse_start(0);
        send_stream(0, 32'h00_03_02_FD, 4, 0);
        pulse_start(0);
        check("t5_hold", {31'd0, hold_a}, 1);
        send_stream(0, 40'h01_05_03_C0_3B, 5, 0);
        repeat (3) @(posedge clk); #1;
        check_three_words("t5", wb);
        check("t5_err",   {31'd0, err_a}, 0);
        check("t5_ndone", done_a_n - db,  1);

        // Reset lands on the edge that would accept the second W_LO.
        wb = wr_a_n; db = done_a_n;
        pulse_start(0);
        send_stream(0, 40'h00_03_02_FD_01, 5, 0);
        @(negedge clk);
        valid_a = 1'b1; data_a = 8'h05; rst_n = 1'b0;
        @(posedge clk); #1;
        valid_a = 1'b0;
        check("t6_ready", {31'd0, ready_a}, 0);
        check("t6_we",    {31'd0, we_a},    0);
        check("t6_addr",  {22'd0, addr_a},  0);
        check("t6_wdata", {22'd0, wdata_a}, 0);
        check("t6_hold",  {31'd0, hold_a},  0);
        check("t6_done",  {31'd0, done_a},  0);
        check("t6_err",   {31'd0, err_a},   0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk); #1;
        check("t6_nwr",   wr_a_n - wb,   1);
        check("t6_d0",    {22'd0, wr_a_data[wb]}, 32'h2FD);
        check("t6_ndone", done_a_n - db, 0);

        // Base 2: count 0x3FF overflows, aborts right after CNT_LO.
        pulse_start(1);
        send(1, 8'h03, 0);
        send(1, 8'hFF, 0);
        check("t7_done",  {31'd0, done_b},  1);
        check("t7_err",   {31'd0, err_b},   1);
        check("t7_ready", {31'd0, ready_b}, 0);
        @(posedge clk); #1;
        check("t7_done_1cy", {31'd0, done_b}, 0);
        check("t7_err_held", {31'd0, err_b},  1);
        check("t7_nwr",      wr_b_n,          0);

        // Base 2: one word lands at address 2.
        pulse_start(1);
        check("t8_err_clr", {31'd0, err_b}, 0);
        send_stream(1, 40'h00_01_00_7F_7E, 5, 0);
        repeat (3) @(posedge clk); #1;
        check("t8_nwr",  wr_b_n, 1);
        check("t8_addr", {22'd0, wr_b_addr[0]}, 32'h002);
        check("t8_data", {22'd0, wr_b_data[0]}, 32'h07F);
        check("t8_err",  {31'd0, err_b}, 0);
        check("t8_ndone", done_b_n, 2);

        check("ready_only_in_byte_states", inv_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
